// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute/memory/writeback sequencing.
// Optional jal/jr support is enabled by defining CTRL_JAL_EN.
module multicycle_ctrl #(
  parameter int unsigned CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              ext_zero,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic [1:0]        reg_dst,
  output logic [1:0]        mem_to_reg,
  output logic              reg_write,
  output logic              pc_en,
  output logic [1:0]        pc_source,
  output logic              illegal_insn
);

  localparam logic [CTRL_W-1:0] ALUOP_ADD  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALUOP_ADDU = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALUOP_SUB  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALUOP_SUBU = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ALUOP_AND  = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ALUOP_OR   = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] ALUOP_XOR  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] ALUOP_NOR  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ALUOP_SLT  = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] ALUOP_SLTU = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] ALUOP_SLL  = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] ALUOP_SRL  = CTRL_W'(12);
  localparam logic [CTRL_W-1:0] ALUOP_SRA  = CTRL_W'(13);
  localparam logic [CTRL_W-1:0] ALUOP_SLLV = CTRL_W'(14);
  localparam logic [CTRL_W-1:0] ALUOP_SRLV = CTRL_W'(15);
  localparam logic [CTRL_W-1:0] ALUOP_SRAV = CTRL_W'(16);
  localparam logic [CTRL_W-1:0] ALUOP_LUI  = CTRL_W'(17);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_MEM_WB, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP
  } state_e;

  state_e state_q, state_d;

  logic              r_legal, r_shamt, i_legal, i_zext, is_jal, is_jr;
  logic [CTRL_W-1:0] r_alu, i_alu;

  // Instruction-field decode; IR is stable from DECODE onwards so this is purely combinational.
  always_comb begin
    r_legal = 1'b1;
    r_shamt = 1'b0;
    r_alu   = '0;
    unique case (funct)
      FN_SLL:  begin r_alu = ALUOP_SLL; r_shamt = 1'b1; end
      FN_SRL:  begin r_alu = ALUOP_SRL; r_shamt = 1'b1; end
      FN_SRA:  begin r_alu = ALUOP_SRA; r_shamt = 1'b1; end
      FN_SLLV: r_alu = ALUOP_SLLV;
      FN_SRLV: r_alu = ALUOP_SRLV;
      FN_SRAV: r_alu = ALUOP_SRAV;
      FN_ADD:  r_alu = ALUOP_ADD;
      FN_ADDU: r_alu = ALUOP_ADDU;
      FN_SUB:  r_alu = ALUOP_SUB;
      FN_SUBU: r_alu = ALUOP_SUBU;
      FN_AND:  r_alu = ALUOP_AND;
      FN_OR:   r_alu = ALUOP_OR;
      FN_XOR:  r_alu = ALUOP_XOR;
      FN_NOR:  r_alu = ALUOP_NOR;
      FN_SLT:  r_alu = ALUOP_SLT;
      FN_SLTU: r_alu = ALUOP_SLTU;
      default: r_legal = 1'b0;
    endcase

    i_legal = 1'b1;
    i_zext  = 1'b0;
    i_alu   = '0;
    unique case (op)
      OP_ADDI, OP_ADDIU: i_alu = ALUOP_ADD;
      OP_SLTI:  i_alu = ALUOP_SLT;
      OP_SLTIU: i_alu = ALUOP_SLTU;
      OP_ANDI:  begin i_alu = ALUOP_AND; i_zext = 1'b1; end
      OP_ORI:   begin i_alu = ALUOP_OR;  i_zext = 1'b1; end
      OP_XORI:  begin i_alu = ALUOP_XOR; i_zext = 1'b1; end
      OP_LUI:   i_alu = ALUOP_LUI;
      default:  i_legal = 1'b0;
    endcase

`ifdef CTRL_JAL_EN
    is_jal = (op == OP_JAL);
    is_jr  = (op == OP_RTYPE) && (funct == FN_JR);
`else
    is_jal = 1'b0;
    is_jr  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    alu_ctrl     = '0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    ext_zero     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    reg_write    = 1'b0;
    pc_en        = 1'b0;
    pc_source    = 2'b00;
    illegal_insn = 1'b0;

    unique case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALUOP_ADD;
        pc_en     = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALUOP_ADD;
        if (op == OP_LW || op == OP_SW)              state_d = S_MEM_ADDR;
        else if (is_jr)                              state_d = S_JUMP;
        else if (op == OP_RTYPE && r_legal)          state_d = S_EXEC_R;
        else if (i_legal)                            state_d = S_EXEC_I;
        else if (op == OP_BEQ || op == OP_BNE)       state_d = S_BRANCH;
        else if (op == OP_J || is_jal)               state_d = S_JUMP;
        else begin
          illegal_insn = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_ctrl  = ALUOP_ADD;
        state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = r_shamt ? 2'b10 : 2'b01;
        alu_ctrl  = r_alu;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_ctrl  = i_alu;
        ext_zero  = i_zext;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_dst   = (op == OP_RTYPE) ? 2'b01 : 2'b00;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_ctrl  = ALUOP_SUB;
        pc_source = 2'b01;
        pc_en     = (op == OP_BEQ) ? zero : ~zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_en     = 1'b1;
        pc_source = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          reg_write  = 1'b1;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions against a per-instruction
// cycle-sequence model. Define CTRL_JAL_EN here as well as in the RTL build to check jal/jr.
module tb_multicycle_ctrl;

  localparam logic [5:0] A_ADD = 6'd1,  A_ADDU = 6'd2,  A_SUB = 6'd3,  A_SUBU = 6'd4;
  localparam logic [5:0] A_AND = 6'd5,  A_OR   = 6'd6,  A_XOR = 6'd7,  A_NOR  = 6'd8;
  localparam logic [5:0] A_SLT = 6'd9,  A_SLTU = 6'd10, A_SLL = 6'd11, A_SRL  = 6'd12;
  localparam logic [5:0] A_SRA = 6'd13, A_SLLV = 6'd14, A_SRLV = 6'd15, A_SRAV = 6'd16;
  localparam logic [5:0] A_LUI = 6'd17;

  typedef struct packed {
    logic [5:0] alu;
    logic [1:0] sa, sb;
    logic       ez, iord, mr, mw, irw;
    logic [1:0] rd, m2r;
    logic       rw, pce;
    logic [1:0] ps;
    logic       ill;
  } ov_t;

  logic       clk, rst_n, zero;
  logic [5:0] op, funct;
  logic [5:0] alu_ctrl;
  logic [1:0] alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_source;
  logic       ext_zero, iord, mem_read, mem_write, ir_write, reg_write, pc_en, illegal_insn;
  ov_t        got;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  ov_t         exp_q[$];

  multicycle_ctrl #(.CTRL_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_en(pc_en),
    .pc_source(pc_source), .illegal_insn(illegal_insn)
  );

  assign got = {alu_ctrl, alu_src_a, alu_src_b, ext_zero, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, pc_en, pc_source, illegal_insn};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
  endtask

  // Builds the expected per-cycle output sequence of one instruction from its class.
  function automatic void build_expected(input logic [5:0] o, input logic [5:0] f, input logic z);
    ov_t v;
    logic [5:0] a;
    bit legal_r, shift_r, legal_i, zx;
    bit jal_ok, jr_ok;
`ifdef CTRL_JAL_EN
    jal_ok = (o == 6'h03);
    jr_ok  = (o == 6'h00) && (f == 6'h08);
`else
    jal_ok = 0;
    jr_ok  = 0;
`endif
    exp_q.delete();
    v = '0; v.mr = 1; v.irw = 1; v.sb = 2'b01; v.alu = A_ADD; v.pce = 1;
    exp_q.push_back(v);
    v = '0; v.sb = 2'b11; v.alu = A_ADD;

    legal_r = 1; shift_r = 0; a = '0;
    case (f)
      6'h00: begin a = A_SLL; shift_r = 1; end
      6'h02: begin a = A_SRL; shift_r = 1; end
      6'h03: begin a = A_SRA; shift_r = 1; end
      6'h04: a = A_SLLV;  6'h06: a = A_SRLV; 6'h07: a = A_SRAV;
      6'h20: a = A_ADD;   6'h21: a = A_ADDU; 6'h22: a = A_SUB;  6'h23: a = A_SUBU;
      6'h24: a = A_AND;   6'h25: a = A_OR;   6'h26: a = A_XOR;  6'h27: a = A_NOR;
      6'h2A: a = A_SLT;   6'h2B: a = A_SLTU;
      default: legal_r = 0;
    endcase

    if (o == 6'h23 || o == 6'h2B) begin
      exp_q.push_back(v);
      v = '0; v.sa = 2'b01; v.sb = 2'b10; v.alu = A_ADD; exp_q.push_back(v);
      v = '0; v.iord = 1;
      if (o == 6'h23) begin
        v.mr = 1; exp_q.push_back(v);
        v = '0; v.m2r = 2'b01; v.rw = 1; exp_q.push_back(v);
      end else begin
        v.mw = 1; exp_q.push_back(v);
      end
    end else if (jr_ok) begin
      exp_q.push_back(v);
      v = '0; v.pce = 1; v.ps = 2'b11; exp_q.push_back(v);
    end else if (o == 6'h00 && legal_r) begin
      exp_q.push_back(v);
      v = '0; v.alu = a; v.sa = shift_r ? 2'b10 : 2'b01; exp_q.push_back(v);
      v = '0; v.rd = 2'b01; v.rw = 1; exp_q.push_back(v);
    end else if (o >= 6'h08 && o <= 6'h0F) begin
      legal_i = 1; zx = (o >= 6'h0C && o <= 6'h0E);
      case (o)
        6'h08, 6'h09: a = A_ADD;
        6'h0A: a = A_SLT;  6'h0B: a = A_SLTU;
        6'h0C: a = A_AND;  6'h0D: a = A_OR;   6'h0E: a = A_XOR;
        default: a = A_LUI;
      endcase
      exp_q.push_back(v);
      v = '0; v.alu = a; v.sa = 2'b01; v.sb = 2'b10; v.ez = zx; exp_q.push_back(v);
      v = '0; v.rw = legal_i; exp_q.push_back(v);
    end else if (o == 6'h04 || o == 6'h05) begin
      exp_q.push_back(v);
      v = '0; v.sa = 2'b01; v.alu = A_SUB; v.ps = 2'b01;
      v.pce = (o == 6'h04) ? z : !z;
      exp_q.push_back(v);
    end else if (o == 6'h02 || jal_ok) begin
      exp_q.push_back(v);
      v = '0; v.pce = 1; v.ps = 2'b10;
      if (jal_ok) begin v.rd = 2'b10; v.m2r = 2'b10; v.rw = 1; end
      exp_q.push_back(v);
    end else begin
      v.ill = 1; exp_q.push_back(v);
    end
  endfunction

  // Runs one instruction starting in FETCH; optionally asserts reset during cycle reset_at.
  task automatic run_insn(input logic [5:0] o, input logic [5:0] f, input logic z, input int reset_at);
    build_expected(o, f, z);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin op = o; funct = f; zero = z; end
      #1;
      check_eq($sformatf("op%02h_fn%02h_z%0d_cyc%0d", o, f, z, k), 32'(got), 32'(exp_q[k]));
      if (k == reset_at) begin
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset_outputs", 32'(got), 32'h0);
        @(negedge clk);
        #1 check_eq("in_reset_outputs", 32'(got), 32'h0);
        rst_n = 1'b1;
        #1 check_eq("init_after_reset", 32'(got), 32'h0);
        break;
      end
    end
  endtask

  logic [5:0] ops_tbl[16];
  logic [5:0] fn_tbl[16];

  initial begin
    ops_tbl = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                6'h03, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h3F};
    fn_tbl  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20,
                6'h21, 6'h22, 6'h23, 6'h24, 6'h27, 6'h2A, 6'h2B, 6'h01};
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_eq("reset_outputs", 32'(got), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("init_outputs", 32'(got), 32'h0);

    run_insn(6'h23, 6'h15, 1'b0, -1);     // lw
    run_insn(6'h00, 6'h00, 1'b0, -1);     // sll
    run_insn(6'h0D, 6'h3A, 1'b1, -1);     // ori
    run_insn(6'h04, 6'h00, 1'b1, -1);     // beq taken
    run_insn(6'h04, 6'h00, 1'b0, -1);     // beq not taken
    run_insn(6'h05, 6'h00, 1'b1, -1);     // bne not taken
    run_insn(6'h05, 6'h00, 1'b0, -1);     // bne taken
    run_insn(6'h3F, 6'h00, 1'b0, -1);     // illegal op
    run_insn(6'h03, 6'h00, 1'b0, -1);     // jal
    run_insn(6'h00, 6'h08, 1'b0, -1);     // jr
    run_insn(6'h2B, 6'h00, 1'b0, -1);     // sw
    run_insn(6'h23, 6'h00, 1'b0, 3);      // lw interrupted in MEM_RD
    run_insn(6'h00, 6'h20, 1'b0, -1);     // add after reset

    for (int n = 0; n < 400; n++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops_tbl[$urandom_range(0, 15)];
      f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(0, 15)];
      run_insn(o, f, 1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
